// File: rtl/pll_sup_pkg.sv
// rtl/pll_sup_pkg.sv - shared state encoding, constants and width helpers for the PLL lock supervisor
package pll_sup_pkg;

   localparam int SYNC_STAGES = 2;

   typedef enum logic [2:0] {
      ST_PLL_RESET = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_STABLE    = 3'd2,
      ST_RUN       = 3'd3,
      ST_FAIL      = 3'd4
   } pll_sup_state_t;

   // Bits needed to hold 0..n-1; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/pll_lock_supervisor_if.sv
// rtl/pll_lock_supervisor_if.sv - PLL-side and status signals of the supervisor; PLL_LOSS_COUNT_EN adds loss_cnt
interface pll_lock_supervisor_if #(
   parameter int MAX_RETRIES = 3
);
   localparam int RW = pll_sup_pkg::cnt_width(MAX_RETRIES + 1);

   logic          pll_locked;
   logic          pll_rst;
   logic          sys_rst;
   logic          lock_fail;
   logic [RW-1:0] retry_cnt;
   logic [2:0]    state_o;
`ifdef PLL_LOSS_COUNT_EN
   logic [7:0]    loss_cnt;
`endif

   // Supervisor side
   modport master (
      input  pll_locked,
      output pll_rst,
      output sys_rst,
      output lock_fail,
      output retry_cnt,
`ifdef PLL_LOSS_COUNT_EN
      output loss_cnt,
`endif
      output state_o
   );

   // PLL / system side
   modport slave (
      output pll_locked,
      input  pll_rst,
      input  sys_rst,
      input  lock_fail,
      input  retry_cnt,
`ifdef PLL_LOSS_COUNT_EN
      input  loss_cnt,
`endif
      input  state_o
   );

endinterface

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - generic multi-flop single-bit synchronizer with async active-high reset
module sync_2ff
   import pll_sup_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] sync_q;

   // Shift the asynchronous input through the synchronizer chain
   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync_q <= '0;
      else     sync_q <= {sync_q[SYNC_STAGES-2:0], d};
   end

   assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - PLL reset/lock qualification FSM with bounded retries; PLL_LOSS_COUNT_EN adds loss_cnt
module pll_lock_supervisor
   import pll_sup_pkg::*;
#(
   parameter int RST_PULSE_CYCLES    = 16,
   parameter int LOCK_TIMEOUT_CYCLES = 50000,
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int MAX_RETRIES         = 3
)(
   input  logic                  refclk,
   input  logic                  rst,
   pll_lock_supervisor_if.master bus
);

   localparam int CW = cnt_width(max3(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES));
   localparam int RW = cnt_width(MAX_RETRIES + 1);

   localparam logic [CW-1:0] RST_LAST     = CW'(RST_PULSE_CYCLES - 1);
   localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
   localparam logic [RW-1:0] RETRY_MAX    = RW'(MAX_RETRIES);

   pll_sup_state_t state_q, state_d;
   logic [CW-1:0]  cnt_q;
   logic [RW-1:0]  retry_q, retry_d;
   logic           locked_s;

   sync_2ff u_lock_sync (
      .clk (refclk),
      .rst (rst),
      .d   (bus.pll_locked),
      .q   (locked_s)
   );

   // State and retry registers
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         state_q <= ST_PLL_RESET;
         retry_q <= '0;
      end else begin
         state_q <= state_d;
         retry_q <= retry_d;
      end
   end

   // Shared phase timer: restarts on any state change, frozen in the untimed states
   always_ff @(posedge refclk or posedge rst) begin
      if (rst)                        cnt_q <= '0;
      else if (state_d != state_q)    cnt_q <= '0;
      else if (state_q inside {ST_PLL_RESET, ST_WAIT_LOCK, ST_STABLE})
                                      cnt_q <= cnt_q + CW'(1);
   end

   // Next-state and retry bookkeeping; lock beats timeout in WAIT_LOCK
   always_comb begin
      state_d = state_q;
      retry_d = retry_q;
      unique case (state_q)
         ST_PLL_RESET: begin
            if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
         end
         ST_WAIT_LOCK: begin
            if (locked_s) begin
               state_d = ST_STABLE;
            end else if (cnt_q == TIMEOUT_LAST) begin
               if (retry_q == RETRY_MAX) begin
                  state_d = ST_FAIL;
               end else begin
                  state_d = ST_PLL_RESET;
                  retry_d = retry_q + RW'(1);
               end
            end
         end
         ST_STABLE: begin
            if (!locked_s) begin
               state_d = ST_WAIT_LOCK;
            end else if (cnt_q == STABLE_LAST) begin
               state_d = ST_RUN;
               retry_d = '0;
            end
         end
         ST_RUN: begin
            if (!locked_s) state_d = ST_PLL_RESET;
         end
         ST_FAIL: begin
            state_d = ST_FAIL;
         end
         default: begin
            state_d = ST_PLL_RESET;
            retry_d = '0;
         end
      endcase
   end

`ifdef PLL_LOSS_COUNT_EN
   logic [7:0] loss_q;

   // Saturating count of lock losses seen while running
   always_ff @(posedge refclk or posedge rst) begin
      if (rst)
         loss_q <= '0;
      else if (state_q == ST_RUN && state_d == ST_PLL_RESET && loss_q != 8'hFF)
         loss_q <= loss_q + 8'd1;
   end

   assign bus.loss_cnt = loss_q;
`endif

   assign bus.pll_rst   = (state_q == ST_PLL_RESET);
   assign bus.sys_rst   = (state_q != ST_RUN);
   assign bus.lock_fail = (state_q == ST_FAIL);
   assign bus.retry_cnt = retry_q;
   assign bus.state_o   = state_q;

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
Supervises a PLL wrapper instance. It drives the PLL's reset, watches its asynchronous `locked` output, and qualifies lock stability. It releases a downstream system reset only after lock has been held continuously. Lock-acquisition timeouts are retried a bounded number of times, and lock loss during operation triggers a full re-lock. It runs on the PLL reference clock, so it never depends on the clock it supervises.

Parameters:
- RST_PULSE_CYCLES, 16: refclk cycles `pll_rst` is held high per attempt (minimum 1).
- LOCK_TIMEOUT_CYCLES, 50000: refclk cycles allowed in WAIT_LOCK before an attempt is declared failed (1 ms at 50 MHz).
- LOCK_STABLE_CYCLES, 1024: consecutive synchronized-locked cycles required before `sys_rst` release.
- MAX_RETRIES, 3: re-attempts after the first; total attempts = MAX_RETRIES+1.

Ports:
- refclk, in, 1: reference clock, the single clock.
- rst, in, 1: asynchronous active-high reset.
- pll_locked, in, 1: PLL locked indication; asynchronous to refclk.
- pll_rst, out, 1: reset to the PLL, active-high.
- sys_rst, out, 1: downstream system reset, active-high.
- lock_fail, out, 1: sticky; retries exhausted.
- retry_cnt, out, $clog2(MAX_RETRIES+1): failed attempts in the current acquisition.
- state_o, out, 3: current FSM state encoding, for debug.

Behaviour:
- Reset is asynchronous and active-high: one clock (`refclk`), asynchronous active-high reset `rst`.
- While `rst` is high, all flops clear. State = PLL_RESET, `pll_rst`=1, `sys_rst`=1, `lock_fail`=0, `retry_cnt`=0, internal counter=0, synchronizer=0.
- `pll_locked` passes through a 2-flop synchronizer; `locked_s` lags the input by 2 refclk edges.
- All outputs are registered or decoded directly from the state register; there are no combinational input-to-output paths.
- One shared cycle counter, cleared on every state transition. "Count reaches N" means `cnt == N-1` in the current cycle, so the state lasts exactly N cycles.
- PLL_RESET: `pll_rst`=1, `sys_rst`=1. After RST_PULSE_CYCLES cycles, go to WAIT_LOCK.
- WAIT_LOCK: `pll_rst`=0, `sys_rst`=1.
  - If `locked_s`=1, go to STABLE.
  - Otherwise, on timeout reaching LOCK_TIMEOUT_CYCLES:
    - if `retry_cnt == MAX_RETRIES`, go to FAIL;
    - else increment `retry_cnt` and go to PLL_RESET.
  - Lock and timeout in the same cycle: lock wins.
- STABLE: `pll_rst`=0, `sys_rst`=1.
  - If `locked_s`=0, go to WAIT_LOCK. The timeout restarts and `retry_cnt` is unchanged (glitch tolerance).
  - After LOCK_STABLE_CYCLES cycles, go to RUN.
- RUN: `pll_rst`=0, `sys_rst`=0, `retry_cnt` cleared on entry.
  - If `locked_s`=0, go to PLL_RESET. `sys_rst` reasserts on the same edge the state changes (1 cycle after `locked_s` falls) and `retry_cnt` restarts at 0.
- FAIL: `pll_rst`=0, `sys_rst`=1, `lock_fail`=1. Terminal until `rst`; `locked_s` is ignored.
- Reset mid-operation: `rst` asserted in any state forces the reset values immediately (asynchronously). Release restarts from PLL_RESET.
- `state_o` encoding: 0=PLL_RESET, 1=WAIT_LOCK, 2=STABLE, 3=RUN, 4=FAIL.
- Counter width: $clog2 of the max(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES) parameter. No wrap is possible because every state exits at its limit.

Optional Feature:
- Macro: PLL_LOSS_COUNT_EN.
- Defined: adds output port `loss_cnt` [7:0]. It increments on every RUN→PLL_RESET transition, saturates at 255, and clears only on `rst`.
- Undefined: the port and counter are absent, and all other behaviour is identical.

Decomposition:
- Shared package `pll_sup_pkg`:
  - state enum `pll_sup_state_t` (3-bit, encoding above);
  - localparam `SYNC_STAGES`=2.
- One sub-module, `sync_2ff`: generic 2-flop bit synchronizer with async active-high reset, reused elsewhere for other async status inputs.
- The FSM and counters stay in the top-level module.

Test Plan:
Parameters for all scenarios: RST_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=20, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2. Cycle 0 = first edge after `rst` release.
1. `pll_locked` tied 1 from before `rst` release → `pll_rst`=1 for cycles 0-3; WAIT_LOCK at 4; STABLE at 5-12; `sys_rst` falls at cycle 13; `lock_fail`=0.
2. `pll_locked` tied 0 → three 24-cycle attempts; `retry_cnt` steps 0→1→2; FAIL entered at cycle 72 with `lock_fail`=1, `sys_rst`=1, `pll_rst`=0; held for 200 further cycles.
3. `pll_locked` rises at cycle 6, drops for 1 cycle at cycle 10, then stays high → STABLE aborts to WAIT_LOCK, re-enters STABLE, reaches RUN; `retry_cnt` remains 0.
4. In RUN, `pll_locked` falls → `sys_rst`=1 and `pll_rst`=1 exactly 3 edges after the input falls; full re-lock then completes with lock restored; with PLL_LOSS_COUNT_EN, `loss_cnt`=1.
5. `rst` pulsed asynchronously mid-STABLE (not clock-aligned) → all outputs return to reset values before the next edge; the sequence restarts per scenario 1.
6. With PLL_LOSS_COUNT_EN, 260 forced lock losses from RUN → `loss_cnt` saturates at 255.
